vdg_pixel_serialiser: RTL
=========================

# vdg_pixel_serialiser

Parametrised pixel serialiser for the ProtoVDG video path. It latches one display byte per `load` strobe together with its mode attributes, and generates alphanumeric, semigraphic or graphics pixels. Pixels shift out on a dot-clock enable as registered RGB. Mode changes take effect only at byte boundaries. The block sits between the display-address/fetch logic and the RGB DAC pins.

## Interface
Parameters:
- `CH_W`, 3: bits per colour channel; `rgb` is `3*CH_W` wide. Palette entries are defined at 3 bits and left-aligned, with the MSBs replicated into the extra LSBs.
- `HSCALE`, 1: pixel-slot repetition (1, 2 or 4); every slot is held `HSCALE` pixel_en cycles.
- `ROW_W`, 4: character row-counter width.

Ports:
- `clk`  in  1  system clock. One clock domain. Reset is synchronous and active-high.
- `reset`  in  1  synchronous, active-high reset.
- `pixel_en`  in  1  dot-clock enable.
- `load`  in  1  byte strobe; `inData` and attributes are valid in this cycle.
- `inData`  in  8  display byte.
- `mode`  in  4  graphics mode; bit0 selects resolution (1) or colour (0). Bits 3:1 are reserved and ignored.
- `css`, `AnG`, `AnS`, `Inv`, `InE`  in  1 each  colour set, graphics, semigraphics, invert, and invert-from-data enable.
- `row`  in  `ROW_W`  character row within the cell.
- `font_addr`  out  `6+ROW_W`  combinational `{inData[5:0], row}`.
- `font_data`  in  8  asynchronous font ROM output; sampled on `load`.
- `de`  in  1  display enable; used only under `VDG_BORDER_EN`.
- `rgb`  out  `3*CH_W`  registered pixel, R in the MSBs and B in the LSBs.
- `ready`  out  1  high when the current byte's final slot is being emitted, or when idle.
- `underrun`  out  1  sticky; cleared by reset only.

## Operation
Palette (3-bit R,G,B octal):
- green 070, yellow 770, blue 007, red 700, buff 777, cyan 077, magenta 707, orange 740.
- black 000, dark green 020, dark orange 200.

Mode capture:
- On `load`, `AnG`, `AnS`, `css`, `mode[0]` and the computed invert flag are latched. They do not affect pixels of the byte already in flight.

Pixel generation per latched mode:
- **Alpha** (`AnG=0, AnS=0`): the source is `font_data`, MSB first, 8 slots.
  - invert = `Inv ^ (InE & inData[6])`.
  - Bit XOR invert = 1 gives the foreground colour; 0 gives the background colour.
  - css0: green on dark green. css1: orange on dark orange.
- **Semigraphic** (`AnG=0, AnS=1`): quadrant select depends on `row`.
  - `row<6` uses bits 3 (left 4 slots) and 2 (right 4 slots).
  - Otherwise bits 1 and 0 are used.
  - A set bit gives palette[`inData[6:4]`] in the order green..orange. A clear bit gives black.
- **Graphics resolution** (`AnG=1, mode[0]=1`): 8 x 1bpp, MSB first.
  - A 1 bit gives green (css0) or buff (css1).
  - A 0 bit gives dark green (css0) or black (css1).
- **Graphics colour** (`AnG=1, mode[0]=0`): 4 x 2bpp, pair 7:6 first. Each pixel occupies 2 slots.
  - css0 values 0..3: green, yellow, blue, red.
  - css1 values 0..3: buff, cyan, magenta, orange.

Byte sequencing:
- Every byte lasts `8*HSCALE` pixel_en cycles.
- A slot counter and a repeat counter advance only on `pixel_en`.

State machine:
- IDLE: `rgb` holds black. `load` goes to ACTIVE.
- ACTIVE: emits slots. On the final slot:
  - `load` in the same cycle: the next byte is loaded seamlessly and the state stays ACTIVE.
  - No `load`: go to UNDERRUN.
- UNDERRUN: `rgb` is black and `underrun` is set to 1. `load` goes to ACTIVE.
- A `load` while ACTIVE and not on the final slot restarts with the new byte. This is not an error.

## Timing
Reset state:
- `rgb`=0, `ready`=1, `underrun`=0, state IDLE, all counters 0.
- A reset mid-byte discards the byte.

Load and first pixel:
- A `load` in cycle N loads the shifter at the end of cycle N.
- The first slot's colour appears on `rgb` after the first `pixel_en` edge after N.
- `load` and `pixel_en` asserted together in cycle N is legal. The first pixel then appears at the next `pixel_en` edge.

Output update:
- `rgb` changes only on `pixel_en` cycles.
- `font_data` must be stable in the `load` cycle.
- `ready` is combinational from the state and counters.
- `reset` has priority over `load`.

## Configuration
- `VDG_BORDER_EN` defined:
  - While `de=0` on a pixel_en edge, `rgb` shows the border colour: black for alpha and semigraphic modes; green (css0) or buff (css1) for graphics modes, using the current un-latched inputs.
  - Slot counters freeze while `de=0`.
  - `underrun` is not set while `de=0`.
- `VDG_BORDER_EN` undefined: `de` is ignored.

## Test plan
- Reset, then no load for 20 pixel_en cycles -> `rgb`=000, `ready`=1, `underrun`=0.
- `HSCALE=1`, graphics resolution, css0, byte A5 loaded with `load` re-asserted on every final slot -> slot sequence 070,020,070,020,020,070,020,070, repeating gap-free with `underrun`=0.
- Graphics colour, css1, byte 1B -> pixel pairs buff,cyan,magenta,orange. With `HSCALE=2` each colour lasts 4 pixel_en cycles.
- Alpha, css0, `font_data`=F0, `InE`=1, `inData[6]`=1 -> 4 slots of 020 then 4 slots of 070. Toggling `AnG` mid-byte leaves the slots unchanged until the next `load`.
- Semigraphic, inData=0x3A (colour 3 red, bits 1010), row=2 -> 4 slots 700, 4 slots 000. Row=8 -> 4 slots 700, 4 slots 000. No load on the final slot -> `rgb`=000 and `underrun`=1 held.
- With `VDG_BORDER_EN`: `de` low for 5 cycles mid-byte -> border shown, then the byte resumes at the frozen slot. Reset asserted mid-byte -> `rgb`=000 on the next clock.

Source files
------------

// File: rtl/vdg_pixel_serialiser.sv
// vdg_pixel_serialiser: latches one display byte plus mode attributes per load
// strobe and shifts alpha / semigraphic / graphics pixels out as registered RGB
// on the dot-clock enable.
// Optional feature macro: VDG_BORDER_EN (border colour and counter freeze while de=0).
module vdg_pixel_serialiser #(
   parameter int unsigned CH_W   = 3,
   parameter int unsigned HSCALE = 1,
   parameter int unsigned ROW_W  = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  pixel_en,
   input  logic                  load,
   input  logic [7:0]            inData,
   input  logic [3:0]            mode,
   input  logic                  css,
   input  logic                  AnG,
   input  logic                  AnS,
   input  logic                  Inv,
   input  logic                  InE,
   input  logic [ROW_W-1:0]      row,
   output logic [6+ROW_W-1:0]    font_addr,
   input  logic [7:0]            font_data,
   input  logic                  de,
   output logic [3*CH_W-1:0]     rgb,
   output logic                  ready,
   output logic                  underrun
);

   localparam int unsigned REP_W = (HSCALE > 1) ? $clog2(HSCALE) : 1;
   localparam logic [REP_W-1:0] REP_LAST = REP_W'(HSCALE - 1);

   // 3-bit-per-channel palette, octal RGB
   localparam logic [8:0] C_BLACK    = 9'o000;
   localparam logic [8:0] C_GREEN    = 9'o070;
   localparam logic [8:0] C_YELLOW   = 9'o770;
   localparam logic [8:0] C_BLUE     = 9'o007;
   localparam logic [8:0] C_RED      = 9'o700;
   localparam logic [8:0] C_BUFF     = 9'o777;
   localparam logic [8:0] C_CYAN     = 9'o077;
   localparam logic [8:0] C_MAGENTA  = 9'o707;
   localparam logic [8:0] C_ORANGE   = 9'o740;
   localparam logic [8:0] C_DKGREEN  = 9'o020;
   localparam logic [8:0] C_DKORANGE = 9'o200;

   typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_UNDERRUN} state_t;

   state_t             state_q, state_d;
   logic [7:0]         src_q, src_d;
   logic               ang_q, ang_d, ans_q, ans_d, css_q, css_d;
   logic               res_q, res_d, inv_q, inv_d, sg_lo_q, sg_lo_d;
   logic [2:0]         slot_q, slot_d;
   logic [REP_W-1:0]   rep_q, rep_d;
   logic [3*CH_W-1:0]  rgb_q, rgb_d;
   logic               underrun_q, underrun_d;

   logic               final_slot;
   logic               border;
   logic [8:0]         slot_col;
   logic [8:0]         border_col;
   logic               unused_in;

   // Left-align each 3-bit channel and replicate its MSBs into extra LSBs
   function automatic logic [3*CH_W-1:0] expand(input logic [8:0] c);
      logic [3*CH_W-1:0] o;
      o = '0;
      for (int unsigned ch = 0; ch < 3; ch++) begin
         for (int unsigned i = 0; i < CH_W; i++) begin
            o[ch*CH_W + CH_W - 1 - i] = c[ch*3 + 2 - (i % 3)];
         end
      end
      return o;
   endfunction

   assign font_addr  = {inData[5:0], row};
   assign final_slot = (state_q == ST_ACTIVE) && (slot_q == 3'd7) && (rep_q == REP_LAST);
   assign ready      = (state_q != ST_ACTIVE) || final_slot;
   assign rgb        = rgb_q;
   assign underrun   = underrun_q;
   assign border_col = AnG ? (css ? C_BUFF : C_GREEN) : C_BLACK;

`ifdef VDG_BORDER_EN
   assign border    = ~de;
   assign unused_in = ^mode[3:1];
`else
   assign border    = 1'b0;
   assign unused_in = ^{mode[3:1], de};
`endif

   // Colour of the current slot from the latched byte and latched mode
   always_comb begin
      logic       bit_v;
      logic [1:0] pair;
      bit_v    = src_q[~slot_q];
      pair     = {src_q[{~slot_q[2:1], 1'b1}], src_q[{~slot_q[2:1], 1'b0}]};
      slot_col = C_BLACK;
      if (!ang_q && !ans_q) begin
         if (bit_v ^ inv_q) slot_col = css_q ? C_ORANGE   : C_GREEN;
         else               slot_col = css_q ? C_DKORANGE : C_DKGREEN;
      end else if (!ang_q) begin
         bit_v = slot_q[2] ? (sg_lo_q ? src_q[0] : src_q[2])
                           : (sg_lo_q ? src_q[1] : src_q[3]);
         if (bit_v) begin
            case (src_q[6:4])
               3'd0:    slot_col = C_GREEN;
               3'd1:    slot_col = C_YELLOW;
               3'd2:    slot_col = C_BLUE;
               3'd3:    slot_col = C_RED;
               3'd4:    slot_col = C_BUFF;
               3'd5:    slot_col = C_CYAN;
               3'd6:    slot_col = C_MAGENTA;
               default: slot_col = C_ORANGE;
            endcase
         end
      end else if (res_q) begin
         if (css_q) slot_col = bit_v ? C_BUFF  : C_BLACK;
         else       slot_col = bit_v ? C_GREEN : C_DKGREEN;
      end else begin
         case ({css_q, pair})
            3'b000:  slot_col = C_GREEN;
            3'b001:  slot_col = C_YELLOW;
            3'b010:  slot_col = C_BLUE;
            3'b011:  slot_col = C_RED;
            3'b100:  slot_col = C_BUFF;
            3'b101:  slot_col = C_CYAN;
            3'b110:  slot_col = C_MAGENTA;
            default: slot_col = C_ORANGE;
         endcase
      end
   end

   // Next-state: slot emission on pixel_en, then byte capture on load
   always_comb begin
      state_d    = state_q;
      src_d      = src_q;
      ang_d      = ang_q;
      ans_d      = ans_q;
      css_d      = css_q;
      res_d      = res_q;
      inv_d      = inv_q;
      sg_lo_d    = sg_lo_q;
      slot_d     = slot_q;
      rep_d      = rep_q;
      rgb_d      = rgb_q;
      underrun_d = underrun_q;

      if (pixel_en) begin
         if (border) begin
            rgb_d = expand(border_col);
         end else if (state_q == ST_ACTIVE) begin
            rgb_d = expand(slot_col);
            if (rep_q == REP_LAST) begin
               rep_d  = '0;
               slot_d = slot_q + 3'd1;
            end else begin
               rep_d = rep_q + REP_W'(1);
            end
            if (final_slot && !load) begin
               state_d    = ST_UNDERRUN;
               underrun_d = 1'b1;
            end
         end else begin
            rgb_d = '0;
         end
      end

      // A load overrides the counter advance so the new byte starts at slot 0
      if (load) begin
         state_d = ST_ACTIVE;
         src_d   = (AnG || AnS) ? inData : font_data;
         ang_d   = AnG;
         ans_d   = AnS;
         css_d   = css;
         res_d   = mode[0];
         inv_d   = Inv ^ (InE & inData[6]);
         sg_lo_d = (row >= ROW_W'(6));
         slot_d  = '0;
         rep_d   = '0;
      end
   end

   // State and output registers, synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         src_q      <= '0;
         ang_q      <= 1'b0;
         ans_q      <= 1'b0;
         css_q      <= 1'b0;
         res_q      <= 1'b0;
         inv_q      <= 1'b0;
         sg_lo_q    <= 1'b0;
         slot_q     <= '0;
         rep_q      <= '0;
         rgb_q      <= '0;
         underrun_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         src_q      <= src_d;
         ang_q      <= ang_d;
         ans_q      <= ans_d;
         css_q      <= css_d;
         res_q      <= res_d;
         inv_q      <= inv_d;
         sg_lo_q    <= sg_lo_d;
         slot_q     <= slot_d;
         rep_q      <= rep_d;
         rgb_q      <= rgb_d;
         underrun_q <= underrun_d;
      end
   end

endmodule
